// File: rtl/nios_gpio_pkg.sv
// Shared definitions for the Nios GPIO controller: register map and bus helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a (the bus slave never stalls).
package nios_gpio_pkg;

    // Register map, word addresses on the 3-bit address bus
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/nios_gpio_edge_det.sv
// Pin synchronizer plus rise/fall edge detector with a post-reset arm window.
// Latency: pin sampled at edge k shows on sync_o/rise_o/fall_o after edge k+SYNC_STAGES-1.
// Backpressure: none; free-running every cycle.
// Ports: clk, reset_n (async active-low), pin_i (async pins), sync_o (synchronized pins),
//        rise_o / fall_o (single-cycle edge strobes, held low while not yet armed).
module nios_gpio_edge_det #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // The chain and history flops reset to 0, so a pin held high through reset
    // looks like a rising edge until the chain has filled; the arm counter
    // masks exactly that window.
    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  hist_q;
    logic [2:0]                        arm_q;
    logic [2:0]                        arm_d;
    logic                              armed;

    assign armed  = (arm_q == ARM_CYCLES);
    assign arm_d  = armed ? arm_q : arm_q + 3'd1;
    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = armed ? (sync_o & ~hist_q) : '0;
    assign fall_o = armed ? (~sync_o & hist_q) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            arm_q  <= arm_d;
        end
    end

endmodule

// File: rtl/nios_gpio_ctrl.sv
// Avalon-MM GPIO controller: output/direction regs, set/clear aliases, edge capture, level irq.
// Latency: writes take effect at the write edge; readdata one cycle after the read strobe; irq one cycle after EDGE_CAP/IRQ_MASK.
// Backpressure: none; every access completes in a single cycle.
// Ports: clk, reset_n (async active-low); address/chipselect/write_n/read_n/writedata/byteenable/readdata
//        slave bus; gpio_in (async pins), gpio_out (OUT register), gpio_oe (DIR register), irq (level).
module nios_gpio_ctrl
    import nios_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    input  logic [3:0]       byteenable,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] pin_sync, pin_rise, pin_fall;
    logic [31:0]      be_mask;
    logic [WIDTH-1:0] wmask, wbits, cap_clr, edge_hit;
    logic [31:0]      rd_val;
    logic             wr_en, rd_en;

    // Lanes/bits above WIDTH are intentionally dropped
    logic unused_hi;
    assign unused_hi = ^{writedata, be_mask};

    nios_gpio_edge_det #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_det (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_i   (gpio_in),
        .sync_o  (pin_sync),
        .rise_o  (pin_rise),
        .fall_o  (pin_fall)
    );

    assign wr_en   = chipselect & ~write_n;
    assign rd_en   = chipselect & ~read_n;
    assign be_mask = byte_lane_mask(byteenable);
    assign wmask   = be_mask[WIDTH-1:0];
    assign wbits   = writedata[WIDTH-1:0] & wmask;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        cap_clr   = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     out_d     = (out_q & ~wmask) | wbits;
                ADDR_DIR:      dir_d     = (dir_q & ~wmask) | wbits;
                ADDR_IRQ_MASK: mask_d    = (mask_q & ~wmask) | wbits;
                ADDR_EDGE_CAP: cap_clr   = wbits;
                ADDR_OUTSET:   out_d     = out_q | wbits;
                ADDR_OUTCLR:   out_d     = out_q & ~wbits;
                ADDR_RISE_EN:  rise_en_d = (rise_en_q & ~wmask) | wbits;
                ADDR_FALL_EN:  fall_en_d = (fall_en_q & ~wmask) | wbits;
                default:       ;
            endcase
        end
    end

    // A fresh edge is OR-ed in after the clear, so it wins a same-cycle W1C
    assign edge_hit = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
    assign cap_d    = (cap_q & ~cap_clr) | edge_hit;
    assign irq_d    = |(cap_q & mask_q);

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:     rd_val[WIDTH-1:0] = (out_q & dir_q) | (pin_sync & ~dir_q);
            ADDR_DIR:      rd_val[WIDTH-1:0] = dir_q;
            ADDR_IRQ_MASK: rd_val[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: rd_val[WIDTH-1:0] = cap_q;
            ADDR_RISE_EN:  rd_val[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:  rd_val[WIDTH-1:0] = fall_en_q;
            default:       rd_val = '0;
        endcase
    end

    assign readdata_d = rd_en ? rd_val : readdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q      <= RESET_OUT;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_gpio_ctrl.sv
// Self-checking bench for nios_gpio_ctrl: directed scenarios plus randomized bus/pin traffic
// compared every cycle against a pin-history based reference model.
module tb_nios_gpio_ctrl;
    import nios_gpio_pkg::*;

    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect, write_n, read_n;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic [31:0] gpio_in, gpio_out, gpio_oe;
    logic        irq;

    logic [2:0]  a8;
    logic        cs8, wn8, rn8;
    logic [31:0] wd8, rd8;
    logic [3:0]  be8;
    logic [7:0]  gin8, gout8, goe8;
    logic        irq8;

    nios_gpio_ctrl #(
        .WIDTH(32), .RESET_OUT(32'h0000_00A5), .RESET_DIR(32'h0000_00FF), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .read_n(read_n), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    nios_gpio_ctrl #(
        .WIDTH(8), .RESET_OUT(8'h00), .RESET_DIR(8'h00), .SYNC_STAGES(2)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .address(a8), .chipselect(cs8),
        .write_n(wn8), .read_n(rn8), .writedata(wd8), .byteenable(be8),
        .readdata(rd8), .gpio_in(gin8), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: register contents plus the list of pin values seen at
    // each clock edge since reset release (index 0 = reset state of the chain).
    logic [31:0] m_out, m_dir, m_mask, m_cap, m_ren, m_fen, m_rd;
    logic        m_irq;
    int          m_edge;
    logic [31:0] samp[$];

    function automatic logic [31:0] smp(input int j);
        if (j >= 0 && j < samp.size()) return samp[j];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_out = 32'h0000_00A5; m_dir = 32'h0000_00FF;
        m_mask = '0; m_cap = '0; m_ren = '0; m_fen = '0; m_rd = '0; m_irq = 1'b0;
        m_edge = 0;
        samp = {};
        samp.push_back(32'h0);
    endtask

    task automatic model_step();
        logic [31:0] lm, wb, s_now, s_prev, edges, clr;
        m_edge++;
        samp.push_back(gpio_in);
        // Pin value visible to the logic before edge m was sampled S edges earlier
        s_now  = smp(m_edge - S);
        s_prev = smp(m_edge - S - 1);
        edges  = (m_edge >= S + 2) ? ((s_now & ~s_prev & m_ren) | (~s_now & s_prev & m_fen)) : 32'h0;
        lm = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
        wb = writedata & lm;
        if (chipselect && !read_n) begin
            case (address)
                3'd0: m_rd = (m_out & m_dir) | (s_now & ~m_dir);
                3'd1: m_rd = m_dir;
                3'd2: m_rd = m_mask;
                3'd3: m_rd = m_cap;
                3'd6: m_rd = m_ren;
                3'd7: m_rd = m_fen;
                default: m_rd = 32'h0;
            endcase
        end
        m_irq = |(m_cap & m_mask);
        clr = 32'h0;
        if (chipselect && !write_n) begin
            case (address)
                3'd0: m_out  = (m_out & ~lm) | wb;
                3'd1: m_dir  = (m_dir & ~lm) | wb;
                3'd2: m_mask = (m_mask & ~lm) | wb;
                3'd3: clr    = wb;
                3'd4: m_out  = m_out | wb;
                3'd5: m_out  = m_out & ~wb;
                3'd6: m_ren  = (m_ren & ~lm) | wb;
                default: m_fen = (m_fen & ~lm) | wb;
            endcase
        end
        m_cap = (m_cap & ~clr) | edges;
    endtask

    task automatic compare();
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_oe", gpio_oe, m_dir);
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        chk("readdata", readdata, m_rd);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
        compare();
    endtask

    task automatic bus_idle();
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        address = 3'd0; writedata = 32'h0; byteenable = 4'h0;
        cs8 = 1'b0; wn8 = 1'b1; rn8 = 1'b1; a8 = 3'd0; wd8 = 32'h0; be8 = 4'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b1;
        address = a; writedata = d; byteenable = be;
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [2:0] a);
        chipselect = 1'b1; write_n = 1'b1; read_n = 1'b0;
        address = a; byteenable = 4'hF;
        tick();
        bus_idle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compare();
    endtask

    initial begin
        gin8 = 8'h00;
        gpio_in = 32'h0;
        bus_idle();
        do_reset();

        // Reset values
        chk("rst_gpio_out", gpio_out, 32'h0000_00A5);
        chk("rst_gpio_oe", gpio_oe, 32'h0000_00FF);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst8_gpio_out", {24'h0, gout8}, 32'h0);
        rd(ADDR_DATA);
        chk("rst_data_rd", {24'h0, readdata[7:0]}, 32'h0000_00A5);

        // Set/clear aliases and byte lanes
        wr(ADDR_DATA, 32'h0F0F_0000, 4'hF);
        wr(ADDR_OUTSET, 32'h0000_00F0, 4'hF);
        wr(ADDR_OUTCLR, 32'h0F00_0000, 4'hF);
        chk("setclr", gpio_out, 32'h000F_00F0);
        wr(ADDR_DATA, 32'hFFFF_FF11, 4'b0001);
        chk("byte_lane", gpio_out, 32'h000F_0011);
        rd(ADDR_OUTSET);
        chk("outset_rd0", readdata, 32'h0);

        // Rising edge capture and irq latency on bit 3
        wr(ADDR_IRQ_MASK, 32'h0, 4'hF);
        wr(ADDR_RISE_EN, 32'h8, 4'hF);
        wr(ADDR_FALL_EN, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        wr(ADDR_EDGE_CAP, 32'hFFFF_FFFF, 4'hF);
        wr(ADDR_IRQ_MASK, 32'h8, 4'hF);
        tick();
        gpio_in[3] = 1'b1;
        tick();                         // edge k
        tick();                         // edge k+1
        rd(ADDR_EDGE_CAP);              // edge k+2: returns value after k+1
        chk("cap3_k1", {31'b0, readdata[3]}, 32'h0);
        chk("irq_k2", {31'b0, irq}, 32'h0);
        rd(ADDR_EDGE_CAP);              // edge k+3: returns value after k+2
        chk("cap3_k2", {31'b0, readdata[3]}, 32'h1);
        chk("irq_k3", {31'b0, irq}, 32'h1);
        wr(ADDR_EDGE_CAP, 32'h8, 4'hF);
        chk("irq_hold_w1c", {31'b0, irq}, 32'h1);
        tick();
        chk("irq_drop", {31'b0, irq}, 32'h0);

        // Falling edge racing a W1C of the same bit
        wr(ADDR_RISE_EN, 32'h0, 4'hF);
        wr(ADDR_FALL_EN, 32'h1, 4'hF);
        gpio_in[0] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wr(ADDR_EDGE_CAP, 32'hFFFF_FFFF, 4'hF);
        tick();
        gpio_in[0] = 1'b0;
        tick();                         // edge k
        tick();                         // edge k+1
        wr(ADDR_EDGE_CAP, 32'h1, 4'hF); // edge k+2, same cycle as the fall
        rd(ADDR_EDGE_CAP);
        chk("race_cap0", {31'b0, readdata[0]}, 32'h1);

        // WIDTH=8 instance: bits above WIDTH ignored
        cs8 = 1'b1; wn8 = 1'b0; a8 = ADDR_DIR; wd8 = 32'hFFFF_FFFF; be8 = 4'hF;
        tick();
        wn8 = 1'b1; rn8 = 1'b0;
        tick();
        bus_idle();
        chk("w8_dir_rd", rd8, 32'h0000_00FF);
        chk("w8_oe", {24'h0, goe8}, 32'h0000_00FF);
        chk("w8_irq", {31'b0, irq8}, 32'h0);

        // Read in flight when reset hits is abandoned
        chipselect = 1'b1; read_n = 1'b0; address = ADDR_DATA; byteenable = 4'hF;
        #2;
        do_reset();
        chk("rst_abandon_rd", readdata, 32'h0);

        // Pins high through reset release: the arm window hides the fake edge
        gpio_in = 32'hFFFF_FFFF;
        do_reset();
        wr(ADDR_RISE_EN, 32'hFFFF_FFFF, 4'hF);
        wr(ADDR_IRQ_MASK, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 10; i++) begin
            rd(ADDR_EDGE_CAP);
            chk("arm_cap", readdata, 32'h0);
            chk("arm_irq", {31'b0, irq}, 32'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                chipselect = 1'b1; read_n = 1'b0; write_n = 1'b1; address = ADDR_EDGE_CAP;
                #3;
                do_reset();
            end
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = 1'($urandom_range(0, 1));
            read_n     = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       gpio_in = $urandom;
                1, 2:    gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            tick();
        end
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
